// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM-stage load/store port.
// One access in flight; busy for LATENCY cycles, then a one-cycle done.
module dmem_responder #(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [15:0] rdata,
   output logic        err
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [3:0]          r_cnt;
   logic                r_we;
   logic [15:0]         r_addr;
   logic [15:0]         r_wdata;
   logic [15:0]         r_rdata;
   logic                r_err;
   logic [15:0]         r_mem [2**ADDR_W];

   logic                w_accept;
   logic                w_access;
   logic                w_oor;
   logic [ADDR_W-1:0]   w_idx;

   assign w_accept = req && (r_state == IDLE || r_state == RESP);
   assign w_access = (r_state == WAIT) && (r_cnt == 4'd0);
   assign w_oor    = (r_addr >> ADDR_W) != 16'd0;
   assign w_idx    = r_addr[ADDR_W-1:0];

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (req) w_next = WAIT;
         WAIT:    if (r_cnt == 4'd0) w_next = RESP;
         RESP:    w_next = req ? WAIT : IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
         r_we    <= 1'b0;
         r_addr  <= 16'd0;
         r_wdata <= 16'd0;
         r_rdata <= 16'd0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_we    <= we;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_cnt   <= 4'(LATENCY - 1);
         end else if (r_state == WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_access) begin
            r_err <= w_oor;
            // writes leave rdata holding the last completed read
            if (!r_we) r_rdata <= w_oor ? 16'd0 : r_mem[w_idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_access && r_we && !w_oor) r_mem[w_idx] <= r_wdata;
   end

   assign busy  = (r_state == WAIT);
   assign done  = (r_state == RESP);
   assign err   = (r_state == RESP) && r_err;
   assign rdata = r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed table, random ops vs array model,
// and hand sequences for busy-drop, reset abort and back-to-back timing.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0, we = 1'b0;
   logic [15:0] addr = '0, wdata = '0;
   logic        busy, done, err;
   logic [15:0] rdata;
   logic        req1 = 1'b0, we1 = 1'b0;
   logic [15:0] addr1 = '0, wdata1 = '0;
   logic        busy1, done1, err1;
   logic [15:0] rdata1;

   int checks = 0;
   int errors = 0;

   logic [15:0] m_mem [1024];
   logic [15:0] m_last;

   always #5 clk = ~clk;

   dmem_responder #(.ADDR_W(10), .LATENCY(3)) u_dut (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
      .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .err(err)
   );

   dmem_responder #(.ADDR_W(10), .LATENCY(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .req(req1), .we(we1), .addr(addr1),
      .wdata(wdata1), .busy(busy1), .done(done1), .rdata(rdata1),
      .err(err1)
   );

   typedef struct {
      bit          w;
      logic [15:0] a;
      logic [15:0] d;
      logic [15:0] exp_rd;
      bit          exp_err;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic model_apply(input bit w, input logic [15:0] a,
                              input logic [15:0] d);
      bit oor;
      oor = a >= 16'd1024;
      if (w) begin
         if (!oor) m_mem[a[9:0]] = d;
      end else begin
         m_last = oor ? 16'd0 : m_mem[a[9:0]];
      end
   endtask

   task automatic access(input bit w, input logic [15:0] a,
                         input logic [15:0] d, output logic [15:0] rd,
                         output logic e, output logic dn, output int nb);
      bit ok;
      @(negedge clk);
      req = 1'b1; we = w; addr = a; wdata = d;
      @(posedge clk);
      nb = 0;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         req = 1'b0;
         if (busy) begin
            nb++;
            if (done) chk("done_while_busy", 1, 0);
         end else begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("busy_timeout", 0, 1);
      rd = rdata;
      e  = err;
      dn = done;
   endtask

   task automatic run_op(input string nm, input bit w,
                         input logic [15:0] a, input logic [15:0] d,
                         input logic [15:0] exp_rd, input bit exp_err);
      logic [15:0] rd;
      logic        e, dn;
      int          nb;
      access(w, a, d, rd, e, dn, nb);
      chk({nm, "_busy_len"}, nb, 3);
      chk({nm, "_done"}, dn, 1);
      chk({nm, "_err"}, e, exp_err);
      chk({nm, "_rdata"}, rd, exp_rd);
   endtask

   vec_t vt[$];

   initial begin
      logic [15:0] ra, rd_v;
      bit          rw, oor;
      int          nd;

      #1000000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] ra, rv;
      bit          rw;
      int          nd;

      m_last = 16'd0;
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_rdata", rdata, 16'h0000);
      chk("rst_busy1", busy1, 0);
      @(negedge clk);
      rst_n = 1'b1;

      vt.push_back('{1, 16'h0005, 16'hBEEF, 16'h0000, 0});
      vt.push_back('{0, 16'h0005, 16'h0000, 16'hBEEF, 0});
      vt.push_back('{1, 16'h0000, 16'h1111, 16'hBEEF, 0});
      vt.push_back('{1, 16'h0400, 16'hFFFF, 16'hBEEF, 1});
      vt.push_back('{0, 16'h0000, 16'h0000, 16'h1111, 0});
      vt.push_back('{0, 16'h0400, 16'h0000, 16'h0000, 1});
      vt.push_back('{1, 16'h0003, 16'h00C3, 16'h0000, 0});
      vt.push_back('{0, 16'h0003, 16'h0000, 16'h00C3, 0});
      vt.push_back('{1, 16'h0004, 16'h4444, 16'h00C3, 0});
      vt.push_back('{0, 16'h0004, 16'h0000, 16'h4444, 0});
      vt.push_back('{1, 16'h0001, 16'h0001, 16'h4444, 0});
      vt.push_back('{1, 16'h0002, 16'h0002, 16'h4444, 0});
      vt.push_back('{1, 16'h0007, 16'h7777, 16'h4444, 0});
      vt.push_back('{0, 16'h8000, 16'h0000, 16'h0000, 1});
      vt.push_back('{0, 16'h0007, 16'h0000, 16'h7777, 0});
      foreach (vt[i]) begin
         run_op($sformatf("vec%0d", i), vt[i].w, vt[i].a, vt[i].d,
                vt[i].exp_rd, vt[i].exp_err);
         model_apply(vt[i].w, vt[i].a, vt[i].d);
      end

      for (int i = 8; i < 16; i++) begin
         rv = 16'($urandom);
         run_op("fill", 1, 16'(i), rv, m_last, 0);
         model_apply(1, 16'(i), rv);
      end
      for (int i = 0; i < 150; i++) begin
         rw = 1'($urandom);
         if ($urandom_range(0, 7) == 0)
            ra = 16'h0400 | 16'($urandom);
         else
            ra = 16'($urandom_range(0, 15));
         rv = 16'($urandom);
         if (rw)
            run_op("rnd_wr", 1, ra, rv, m_last, ra >= 16'd1024);
         else
            run_op("rnd_rd", 0, ra, rv,
                   (ra >= 16'd1024) ? 16'd0 : m_mem[ra[9:0]],
                   ra >= 16'd1024);
         model_apply(rw, ra, rv);
      end

      // a request pulsed during WAIT must vanish without a trace
      rv = m_mem[2];
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 16'h0001;
      @(posedge clk);
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 16'h0002; wdata = 16'h1234;
      @(negedge clk);
      req = 1'b0; we = 1'b0;
      nd = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done) begin
            nd++;
            chk("ign_rdata", rdata, m_mem[1]);
         end
      end
      chk("ign_done_cnt", nd, 1);
      model_apply(0, 16'h0001, 16'h0);
      run_op("ign_mem2", 0, 16'h0002, 16'h0, rv, 0);
      model_apply(0, 16'h0002, 16'h0);

      // reset one cycle into a write aborts it
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 16'h0007; wdata = 16'hAAAA;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rstmid_busy", busy, 0);
      chk("rstmid_done", done, 0);
      chk("rstmid_rdata", rdata, 16'h0000);
      nd = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (done || busy) nd++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("rstmid_no_done", nd, 0);
      m_last = 16'd0;
      run_op("rstmid_rd7", 0, 16'h0007, 16'h0, m_mem[7], 0);
      model_apply(0, 16'h0007, 16'h0);

      // LATENCY=1 with req held: busy and done alternate each cycle
      @(negedge clk);
      req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0009; wdata1 = 16'h5A5A;
      nd = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("b2b_excl", busy1 & done1, 0);
         chk("b2b_busy", busy1, (i % 2) == 0);
         if (done1) nd++;
      end
      req1 = 1'b0;
      chk("b2b_done_cnt", nd, 10);
      req1 = 1'b1; we1 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req1 = 1'b0;
      @(negedge clk);
      chk("b2b_rd_done", done1, 1);
      chk("b2b_rd_data", rdata1, 16'h5A5A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
